// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// State encoding plus a helper for pointer/index widths.
package uart_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACK    = 2'd3
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr,
// wrapping modulo NUM_REQ, as one-hot plus index.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx,
  output logic               any
);

  logic [IW-1:0] cand [NUM_REQ];

  // cand[0] is the highest-priority slot (ptr+1)
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cand[i] = IW'((int'(ptr) + i + 1) % NUM_REQ);
    end
  end

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && req[cand[i]]) begin
        any          = 1'b1;
        gnt[cand[i]] = 1'b1;
        gnt_idx      = cand[i];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ requesters,
// with a per-transfer timeout on tx_done.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 65535
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic                      err_o,
  output logic                      busy_o,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      tx_en_o,
  output logic [DATA_W-1:0]         tx_data_o,
  input  logic                      tx_done_i
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  arb_state_e state_q, state_d;

  logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      win_q, win_d;
  logic [NUM_REQ-1:0] grant_d, ack_d;
  logic [DATA_W-1:0]  data_d;
  logic               err_d, busy_d, tx_en_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic [DATA_W-1:0]  bytes [NUM_REQ];

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      bytes[k] = data_i[k*DATA_W +: DATA_W];
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req     (req_i),
    .ptr     (ptr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    grant_d = grant_o;
    data_d  = tx_data_o;
    ack_d   = '0;
    err_d   = 1'b0;
    tx_en_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_LAUNCH;
          grant_d = pick_gnt;
          win_d   = pick_idx;
          data_d  = bytes[pick_idx];
          tx_en_d = 1'b1;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        // done in the same cycle as the timeout still counts as success
        if (tx_done_i) begin
          state_d = ST_ACK;
          ack_d   = grant_o;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= TO_LAST) begin
            state_d = ST_ACK;
            ack_d   = grant_o;
            err_d   = 1'b1;
          end
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        grant_d = '0;
        ptr_d   = win_q;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ptr_q     <= IW'(NUM_REQ - 1);
      win_q     <= '0;
      ack_o     <= '0;
      err_o     <= 1'b0;
      busy_o    <= 1'b0;
      grant_o   <= '0;
      tx_en_o   <= 1'b0;
      tx_data_o <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      ack_o     <= ack_d;
      err_o     <= err_d;
      busy_o    <= busy_d;
      grant_o   <= grant_d;
      tx_en_o   <= tx_en_d;
      tx_data_o <= data_d;
    end
  end

endmodule
